muldiv_ctrl: RTL and testbench

Multi-cycle HI/LO unit controller between the EX stage and the iterative radix-2 divider. Accepts one mult/multu/div/divu per request, holds the pipeline with `stall`, runs a registered 2-cycle multiply internally, sequences the divider handshake, and delivers a single-cycle HI/LO write. Supports cancellation by exception flush at any point.

---
 rtl/muldiv_ctrl.sv | 175 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//
// HI/LO multi-cycle unit controller sitting between the EX stage and an
// iterative radix-2 divider. One mult/multu/div/divu is accepted per request.
// The pipeline is held with `stall` while the operation runs. A 64-bit
// multiply is computed internally from registered operands in one cycle.
// Divides are handed to the external divider through a valid/ready pair.
// The result is delivered to HI/LO as a single-cycle write strobe. An
// exception flush cancels the operation at any point.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous reset, active high
//   op_valid       in   EX holds a mult/div instruction
//   op[1:0]        in   00 mult, 01 multu, 10 div, 11 divu
//   a, b [31:0]    in   rs / rt operand values
//   flush          in   exception flush, cancels the current operation
//   stall          out  freezes the pipeline at and before EX
//   div_opn_valid  out  operands valid to the divider
//   div_sign       out  1 = signed divide
//   div_a, div_b   out  dividend / divisor
//   div_res_ready  out  controller accepts the divider result
//   div_res_valid  in   divider result valid
//   div_result     in   {remainder, quotient}
//   hilo_we        out  one-cycle HI/LO write strobe
//   hi_o, lo_o     out  values written into HI/LO
// ---------------------------------------------------------------------------
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        div_opn_valid,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_res_ready,
  input  logic        div_res_valid,
  input  logic [63:0] div_result,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic                sign_q, sign_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                accept;
  logic [2*DATA_W-1:0] product;

  // Both operands are widened to 33 bits (sign- or zero-extended) so one
  // signed multiplier serves mult and multu; the low 64 bits of the 66-bit
  // product are exact in both cases.
  function automatic logic [2*DATA_W-1:0] mul_full(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y,
    input logic              sgn
  );
    logic signed [DATA_W:0]     xe;
    logic signed [DATA_W:0]     ye;
    logic signed [2*DATA_W+1:0] p;
    xe = {sgn & x[DATA_W-1], x};
    ye = {sgn & y[DATA_W-1], y};
    p  = xe * ye;
    return p[2*DATA_W-1:0];
  endfunction

  // Division by zero never reaches the divider: HI gets the dividend and
  // LO gets all ones, matching the divider's own degenerate result.
  function automatic logic [2*DATA_W-1:0] div_by_zero(
    input logic [DATA_W-1:0] x
  );
    return {x, {DATA_W{1'b1}}};
  endfunction

  assign accept  = (state_q == S_IDLE) && op_valid && !flush;
  assign product = mul_full(opa_q, opb_q, sign_q);

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opa_d  = a;
          opb_d  = b;
          sign_d = ~op[0];
          if (!op[1]) begin
            state_d = S_MUL;
          end else if (b == '0) begin
            {hi_d, lo_d} = div_by_zero(a);
            state_d      = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          {hi_d, lo_d} = product;
          state_d      = S_DONE;
        end
      end
      S_DIV: begin
        // Flush wins over a coincident result: nothing is captured.
        if (flush) begin
          state_d = S_IDLE;
        end else if (div_res_valid) begin
          hi_d    = div_result[63:32];
          lo_d    = div_result[31:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // op_valid here is still the finishing instruction, so it is ignored.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // stall covers the request cycle combinationally so EX is frozen from T0.
  assign stall         = accept || (state_q == S_MUL) || (state_q == S_DIV);
  // Dropping div_opn_valid (any cycle outside DIV) aborts the divider.
  assign div_opn_valid = (state_q == S_DIV);
  assign div_res_ready = (state_q == S_DIV);
  assign div_sign      = sign_q;
  assign div_a         = opa_q;
  assign div_b         = opb_q;
  assign hilo_we       = (state_q == S_DONE) && !flush;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        stall;
  logic        div_opn_valid;
  logic        div_sign;
  logic [31:0] div_a, div_b;
  logic        div_res_ready;
  logic        div_res_valid;
  logic [63:0] div_result;
  logic        hilo_we;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;
  int wcnt  = 0;
  int base;
  logic [31:0] whi [0:31];
  logic [31:0] wlo [0:31];

  muldiv_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid      (op_valid),
    .op            (op),
    .a             (a),
    .b             (b),
    .flush         (flush),
    .stall         (stall),
    .div_opn_valid (div_opn_valid),
    .div_sign      (div_sign),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_res_ready (div_res_ready),
    .div_res_valid (div_res_valid),
    .div_result    (div_result),
    .hilo_we       (hilo_we),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  always #5 clk = ~clk;

  // Record every HI/LO write strobe, sampled mid-low-phase.
  always @(negedge clk) begin
    #2;
    if (hilo_we === 1'b1) begin
      if (wcnt < 32) begin
        whi[wcnt] = hi_o;
        wlo[wcnt] = lo_o;
      end
      wcnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed multiply: T0 accept, T1 MUL, T2 DONE, T3 IDLE (unless hold).
  task automatic run_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp, input string tag, input bit hold);
    @(negedge clk); op_valid = 1'b1; op = o; a = x; b = y; #1;
    chk({tag, "_t0_stall"}, stall, 1);
    @(negedge clk); #1;
    chk({tag, "_t1_stall"}, stall, 1);
    chk({tag, "_t1_we"}, hilo_we, 0);
    @(negedge clk); #1;
    chk({tag, "_done_stall"}, stall, 0);
    chk({tag, "_done_we"}, hilo_we, 1);
    chk({tag, "_done_hilo"}, {hi_o, lo_o}, exp);
    if (!hold) begin
      op_valid = 1'b0;
      @(negedge clk); #1;
      chk({tag, "_idle_stall"}, stall, 0);
      chk({tag, "_idle_we"}, hilo_we, 0);
      chk({tag, "_idle_hold"}, {hi_o, lo_o}, exp);
    end
  endtask

  // Directed divide with a bench divider answering on DIV cycle n.
  task automatic run_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int n, input logic [63:0] res, input string tag);
    @(negedge clk); op_valid = 1'b1; op = o; a = x; b = y; div_res_valid = 1'b0; #1;
    chk({tag, "_t0_stall"}, stall, 1);
    chk({tag, "_t0_opn"}, div_opn_valid, 0);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk); #1;
      chk({tag, "_opn"}, div_opn_valid, 1);
      chk({tag, "_rdy"}, div_res_ready, 1);
      chk({tag, "_sign"}, div_sign, {63'd0, !o[0]});
      chk({tag, "_opnds"}, {div_a, div_b}, {x, y});
      chk({tag, "_stall"}, stall, 1);
      if (i == n) begin
        div_res_valid = 1'b1;
        div_result    = res;
      end
    end
    @(negedge clk); div_res_valid = 1'b0; #1;
    chk({tag, "_done_stall"}, stall, 0);
    chk({tag, "_done_we"}, hilo_we, 1);
    chk({tag, "_done_hilo"}, {hi_o, lo_o}, res);
    chk({tag, "_done_opn"}, div_opn_valid, 0);
    op_valid = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_idle_we"}, hilo_we, 0);
    chk({tag, "_idle_stall"}, stall, 0);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
    div_res_valid = 1'b0; div_result = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_stall", stall, 0);
    chk("rst_we", hilo_we, 0);
    chk("rst_opn", div_opn_valid, 0);
    chk("rst_rdy", div_res_ready, 0);
    chk("rst_sign", div_sign, 0);
    chk("rst_divab", {div_a, div_b}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // mult -1 * 2 and multu 0xFFFFFFFF * 2
    run_mul(2'b00, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, "mult", 1'b0);
    run_mul(2'b01, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, "multu", 1'b0);

    // div -7 / 2 = q -3, r -1; divider answers after 33 cycles
    run_div(2'b10, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD, "div");

    // divu by zero: no divider, one stall cycle
    @(negedge clk); op_valid = 1'b1; op = 2'b11; a = 32'h12345678; b = 32'd0; #1;
    chk("dz_t0_stall", stall, 1);
    chk("dz_t0_opn", div_opn_valid, 0);
    @(negedge clk); #1;
    chk("dz_done_stall", stall, 0);
    chk("dz_done_we", hilo_we, 1);
    chk("dz_done_opn", div_opn_valid, 0);
    chk("dz_done_hilo", {hi_o, lo_o}, 64'h12345678_FFFFFFFF);
    op_valid = 1'b0;
    @(negedge clk); #1;
    chk("dz_idle_we", hilo_we, 0);

    // Flush on 10th DIV cycle
    @(negedge clk); op_valid = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3; #1;
    chk("fl_t0_stall", stall, 1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      chk("fl_div_opn", div_opn_valid, 1);
      if (i == 10) flush = 1'b1;
    end
    @(negedge clk); flush = 1'b0; op_valid = 1'b0; #1;
    chk("fl_after_opn", div_opn_valid, 0);
    chk("fl_after_stall", stall, 0);
    chk("fl_after_we", hilo_we, 0);
    chk("fl_after_hold", {hi_o, lo_o}, 64'h12345678_FFFFFFFF);
    @(negedge clk); #1;
    chk("fl_after2_we", hilo_we, 0);
    run_mul(2'b01, 32'd3, 32'd5, 64'd15, "multu_post_flush", 1'b0);

    // Flush coincident with div_res_valid: no capture, no write
    @(negedge clk); op_valid = 1'b1; op = 2'b11; a = 32'd20; b = 32'd3; #1;
    chk("flres_t0_stall", stall, 1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      chk("flres_opn", div_opn_valid, 1);
    end
    div_res_valid = 1'b1; div_result = {32'd2, 32'd6}; flush = 1'b1;
    @(negedge clk); flush = 1'b0; div_res_valid = 1'b0; op_valid = 1'b0; #1;
    chk("flres_we", hilo_we, 0);
    chk("flres_stall", stall, 0);
    chk("flres_opn_off", div_opn_valid, 0);
    chk("flres_hold", {hi_o, lo_o}, 64'd15);
    @(negedge clk); #1;
    chk("flres_we2", hilo_we, 0);

    // Flush in DONE suppresses the write strobe
    @(negedge clk); op_valid = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4; #1;
    chk("fldone_t0_stall", stall, 1);
    @(negedge clk); #1;
    chk("fldone_t1_stall", stall, 1);
    @(negedge clk); flush = 1'b1; #1;
    chk("fldone_we", hilo_we, 0);
    chk("fldone_stall", stall, 0);
    #2; flush = 1'b0; op_valid = 1'b0;
    @(negedge clk); #1;
    chk("fldone_idle_stall", stall, 0);
    chk("fldone_idle_we", hilo_we, 0);

    // Flush with op_valid in IDLE: not accepted
    @(negedge clk); op_valid = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1; #1;
    chk("flidle_stall", stall, 0);
    @(negedge clk); flush = 1'b0; op_valid = 1'b0; #1;
    chk("flidle_next_stall", stall, 0);
    chk("flidle_next_we", hilo_we, 0);
    @(negedge clk); #1;
    chk("flidle_next2_we", hilo_we, 0);

    // Async reset mid-MUL
    @(negedge clk); op_valid = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6; #1;
    chk("rmul_t0_stall", stall, 1);
    @(negedge clk); #1;
    chk("rmul_t1_stall", stall, 1);
    rst = 1'b1; op_valid = 1'b0; #1;
    chk("rmul_stall", stall, 0);
    chk("rmul_we", hilo_we, 0);
    chk("rmul_opn", div_opn_valid, 0);
    chk("rmul_sign", div_sign, 0);
    chk("rmul_divab", {div_a, div_b}, 64'd0);
    chk("rmul_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk); #1;
    chk("rmul_we2", hilo_we, 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: mult 7 * -3, then div 100 / 7 with op_valid held
    base = wcnt;
    run_mul(2'b00, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, "b2b_mult", 1'b1);
    op = 2'b10; a = 32'd100; b = 32'd7;
    run_div(2'b10, 32'd100, 32'd7, 2, {32'd2, 32'd14}, "b2b_div");
    #3;
    chk("b2b_pulses", wcnt - base, 2);
    chk("b2b_first", {whi[base], wlo[base]}, 64'hFFFFFFFF_FFFFFFEB);
    chk("b2b_second", {whi[base + 1], wlo[base + 1]}, {32'd2, 32'd14});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
